// File: rtl/aes_engine.sv
// Iterative AES encryptor (128/192/256-bit keys): expands the key once, then one round per clock.
// Define AES_ENGINE_CBC_EN to add CBC chaining (iv_load/iv ports and a chain register).
module aes_engine #(
    parameter int KEY_BITS = 128
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [KEY_BITS-1:0] key,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        in_data,
`ifdef AES_ENGINE_CBC_EN
    input  logic                iv_load,
    input  logic [127:0]        iv,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        out_data,
    output logic                busy
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [5:0] LAST_W = 6'(NW - 1);
    localparam logic [2:0] NK_M1  = 3'(NK - 1);
    localparam logic [3:0] NR_R   = 4'(NR);

    generate
        if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
            $error("aes_engine: KEY_BITS must be 128, 192 or 256");
        end
    endgenerate

    typedef enum logic [2:0] {NOKEY, KEYEXP, READY, ROUND, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as b^254 (0 maps to 0), followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // Byte n sits at [127-8n -: 8]; row = n%4, column = n/4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

    state_t         state, state_nxt;
    logic [31:0]    w [NW];
    logic [5:0]     widx;
    logic [2:0]     kmod;
    logic [7:0]     rcon;
    logic [3:0]     rnd;
    logic [127:0]   data_reg;
    logic [127:0]   chain_eff;
    logic           key_fire, in_fire;
    logic [31:0]    w_prev, w_back, kx_temp, w_new;
    logic [5:0]     rk_base;
    logic [127:0]   rk_cur, sb_sr, round_out;

`ifdef AES_ENGINE_CBC_EN
    logic [127:0]   chain;
    assign chain_eff = iv_load ? iv : chain;
`else
    assign chain_eff = '0;
`endif

    assign key_fire = key_valid && key_ready;
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= NOKEY;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        key_ready = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b0;
        case (state)
            NOKEY: begin
                key_ready = 1'b1;
                if (key_valid) state_nxt = KEYEXP;
            end
            KEYEXP: begin
                busy = 1'b1;
                if (widx == LAST_W) state_nxt = READY;
            end
            READY: begin
                key_ready = 1'b1;
                in_ready  = !key_valid;
                if (key_valid)     state_nxt = KEYEXP;
                else if (in_valid) state_nxt = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (rnd == NR_R) state_nxt = DONE;
            end
            DONE: begin
                busy = 1'b1;
                if (out_ready) state_nxt = READY;
            end
            default: state_nxt = NOKEY;
        endcase
    end

    assign w_prev = w[widx - 6'd1];
    assign w_back = w[widx - NK_W];

    always_comb begin
        kx_temp = w_prev;
        if (kmod == 3'd0) begin
            kx_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon, 24'h000000};
        end else if (NK == 8 && kmod == 3'd4) begin
            kx_temp = sub_word(w_prev);
        end
    end

    assign w_new     = w_back ^ kx_temp;
    assign rk_base   = {rnd, 2'b00};
    assign rk_cur    = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
    assign sb_sr     = sub_shift(data_reg);
    assign round_out = ((rnd == NR_R) ? sb_sr : mix_columns(sb_sr)) ^ rk_cur;

    // Key store is deliberately left out of reset; only the FSM forgets the key.
    always_ff @(posedge clock) begin
        if (key_fire) begin
            for (int k = 0; k < NK; k++) begin
                w[k] <= key[KEY_BITS-1-32*k -: 32];
            end
        end else if (state == KEYEXP) begin
            w[widx] <= w_new;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            widx      <= '0;
            kmod      <= '0;
            rcon      <= 8'h01;
            rnd       <= '0;
            data_reg  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
`ifdef AES_ENGINE_CBC_EN
            chain     <= '0;
`endif
        end else begin
            if (key_fire) begin
                widx <= NK_W;
                kmod <= '0;
                rcon <= 8'h01;
            end
            if (state == KEYEXP) begin
                widx <= widx + 6'd1;
                kmod <= (kmod == NK_M1) ? 3'd0 : kmod + 3'd1;
                if (kmod == 3'd0) rcon <= xtime(rcon);
            end
            if (in_fire) begin
                data_reg <= in_data ^ chain_eff ^ {w[0], w[1], w[2], w[3]};
                rnd      <= 4'd1;
            end
            if (state == ROUND) begin
                data_reg <= round_out;
                rnd      <= rnd + 4'd1;
                if (rnd == NR_R) begin
                    out_data  <= round_out;
                    out_valid <= 1'b1;
                end
            end
            if (state == DONE && out_ready) begin
                out_valid <= 1'b0;
`ifdef AES_ENGINE_CBC_EN
                chain     <= out_data;
`endif
            end
`ifdef AES_ENGINE_CBC_EN
            if (state == READY && iv_load) chain <= iv;
`endif
        end
    end

endmodule

// File: tb/tb_aes_engine.sv
// Scoreboard bench for aes_engine: one instance per key size sharing a 256-bit key bus,
// FIPS-197 / SP800-38A vectors, backpressure, key/plaintext priority and mid-round reset.
module tb_aes_engine;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [2:0]   key_valid, key_ready, in_valid, in_ready, out_valid, out_ready, busy;
    logic [255:0] key_all;
    logic [127:0] in_data;
    logic [127:0] out_data [3];
    logic         iv_load;
    logic [127:0] iv;

    logic [127:0] exp_q [$];
    int           n_cmp = 0;
    int           n_err = 0;

    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] KEY_SEQ =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic [127:0] fips_ct [3] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                  128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                                  128'h8ea2b7ca516745bfeafc49904b496089};
    int nr_tab [3] = '{10, 12, 14};
    int kx_tab [3] = '{40, 46, 52};

    always #5 clock = ~clock;

    aes_engine #(.KEY_BITS(128)) u_aes128 (
        .clock(clock), .reset_n(reset_n),
        .key_valid(key_valid[0]), .key_ready(key_ready[0]), .key(key_all[255:128]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data),
`ifdef AES_ENGINE_CBC_EN
        .iv_load(iv_load), .iv(iv),
`endif
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0])
    );

    aes_engine #(.KEY_BITS(192)) u_aes192 (
        .clock(clock), .reset_n(reset_n),
        .key_valid(key_valid[1]), .key_ready(key_ready[1]), .key(key_all[255:64]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data),
`ifdef AES_ENGINE_CBC_EN
        .iv_load(iv_load), .iv(iv),
`endif
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1])
    );

    aes_engine #(.KEY_BITS(256)) u_aes256 (
        .clock(clock), .reset_n(reset_n),
        .key_valid(key_valid[2]), .key_ready(key_ready[2]), .key(key_all),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data),
`ifdef AES_ENGINE_CBC_EN
        .iv_load(iv_load), .iv(iv),
`endif
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .busy(busy[2])
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (out_valid[k] && out_ready[k]) begin
                if (exp_q.size() == 0) check("sb_underflow", 128'(exp_q.size()), 128'd1);
                else                   check("ciphertext", out_data[k], exp_q.pop_front());
            end
        end
    end

    task automatic load_key(input int k, input logic [255:0] kv, input int exp_cycles);
        int n;
        key_all      = kv;
        key_valid[k] = 1'b1;
        n = 0;
        @(negedge clock);
        while (!key_ready[k] && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!key_ready[k]) check("key_accept_timeout", 128'(key_ready[k]), 128'd1);
        @(posedge clock);
        #1 key_valid[k] = 1'b0;
        n = 0;
        while (!key_ready[k] && n < 200) begin
            @(posedge clock);
            #1 n++;
        end
        check("keyexp_cycles", 128'(n), 128'(exp_cycles));
    endtask

    task automatic send_block(input int k, input logic [127:0] pt, input logic [127:0] exp,
                              input int exp_lat);
        int n;
        in_data     = pt;
        in_valid[k] = 1'b1;
        n = 0;
        @(negedge clock);
        while (!in_ready[k] && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready[k]) check("in_accept_timeout", 128'(in_ready[k]), 128'd1);
        @(posedge clock);
        #1 in_valid[k] = 1'b0;
        exp_q.push_back(exp);
        if (exp_lat > 0) begin
            n = 0;
            while (!out_valid[k] && n < 100) begin
                @(posedge clock);
                #1 n++;
            end
            check("latency", 128'(n), 128'(exp_lat));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        check("drain", 128'(exp_q.size()), 128'd0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        key_valid = '0;
        in_valid  = '0;
        out_ready = 3'b111;
        key_all   = '0;
        in_data   = '0;
        iv_load   = 1'b0;
        iv        = '0;
        repeat (3) @(posedge clock);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_key_ready", 128'(key_ready[k]), 128'd1);
            check("rst_in_ready",  128'(in_ready[k]),  128'd0);
            check("rst_out_valid", 128'(out_valid[k]), 128'd0);
            check("rst_out_data",  out_data[k],        128'd0);
            check("rst_busy",      128'(busy[k]),      128'd0);
        end
        #2 reset_n = 1'b1;

        // FIPS-197 appendix C vectors for all three key sizes
        for (int k = 0; k < 3; k++) begin
            load_key(k, KEY_SEQ, kx_tab[k]);
            send_block(k, PT_FIPS, fips_ct[k], nr_tab[k]);
            drain();
        end

        // Backpressure: result held while out_ready is low
        load_key(0, {KEY_B, 128'h0}, 40);
        out_ready[0] = 1'b0;
        send_block(0, PT_B, CT_B, 10);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            check("hold_data",     out_data[0],        CT_B);
            check("hold_valid",    128'(out_valid[0]), 128'd1);
            check("hold_in_ready", 128'(in_ready[0]),  128'd0);
        end
        out_ready[0] = 1'b1;
        @(posedge clock);
        #1 out_ready[0] = 1'b0;
        check("drop_valid", 128'(out_valid[0]), 128'd0);
        check("data_kept",  out_data[0],        CT_B);
        check("ready_back", 128'(in_ready[0]),  128'd1);
        out_ready[0] = 1'b1;
        send_block(0, PT_B, CT_B, 10);
        send_block(0, 128'h6bc1bee22e409f96e93d7e117393172a,
                   128'h3ad77bb40d7a3660a89ecaf32466ef97, 0);
        send_block(0, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                   128'hf5d3d58503b9699de785895a96fdbaaf, 0);
        drain();

        // Key offer wins over a simultaneous plaintext offer
        key_all      = KEY_SEQ;
        in_data      = PT_FIPS;
        key_valid[0] = 1'b1;
        in_valid[0]  = 1'b1;
        @(negedge clock);
        check("prio_in_ready",  128'(in_ready[0]),  128'd0);
        check("prio_key_ready", 128'(key_ready[0]), 128'd1);
        @(posedge clock);
        #1 key_valid[0] = 1'b0;
        check("prio_busy", 128'(busy[0]), 128'd1);
        begin
            int n;
            n = 0;
            while (!in_ready[0] && n < 100) begin
                @(posedge clock);
                #1 n++;
            end
            check("prio_wait", 128'(n), 128'd40);
        end
        @(posedge clock);
        #1 in_valid[0] = 1'b0;
        exp_q.push_back(fips_ct[0]);
        check("prio_accepted", 128'(busy[0]), 128'd1);
        drain();

        // Reset in the middle of a block forgets the key
        in_data     = PT_B;
        in_valid[0] = 1'b1;
        @(posedge clock);
        #1 in_valid[0] = 1'b0;
        repeat (5) @(posedge clock);
        #1 reset_n = 1'b0;
        #2;
        check("abort_out_valid", 128'(out_valid[0]), 128'd0);
        check("abort_busy",      128'(busy[0]),      128'd0);
        #1 reset_n = 1'b1;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clock);
            check("nokey_in_ready",  128'(in_ready[0]),  128'd0);
            check("nokey_out_valid", 128'(out_valid[0]), 128'd0);
        end
        in_valid[0] = 1'b0;
        check("nokey_key_ready", 128'(key_ready[0]), 128'd1);
        load_key(0, {KEY_B, 128'h0}, 40);
        send_block(0, PT_B, CT_B, 10);
        drain();

`ifdef AES_ENGINE_CBC_EN
        // Zero IV: first block equals plain ECB
        iv      = '0;
        iv_load = 1'b1;
        @(posedge clock);
        #1 iv_load = 1'b0;
        send_block(0, PT_B, CT_B, 10);
        drain();
        // SP800-38A CBC, IV loaded in the same cycle as the first block
        iv      = 128'h000102030405060708090a0b0c0d0e0f;
        iv_load = 1'b1;
        send_block(0, 128'h6bc1bee22e409f96e93d7e117393172a,
                   128'h7649abac8119b246cee98e9b12e9197d, 10);
        iv_load = 1'b0;
        send_block(0, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                   128'h5086cb9b507219ee95db113a917678b2, 10);
        drain();
`endif

        check("sb_empty", 128'(exp_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
